// File: rtl/seven_seg_scan_receiver.sv
// Recovers the four digits shown on a multiplexed 4-digit seven-segment bus (SEG + DIG strobes).
// Build macro SEVEN_SEG_RX_DP_CAPTURE_EN: when defined, decimal points are captured into DP.
module seven_seg_scan_receiver #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65535,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] SEG,
  input  logic [3:0] DIG,
  output logic [3:0] CNT1,
  output logic [3:0] CNT2,
  output logic [3:0] CNT3,
  output logic [3:0] CNT4,
  output logic [3:0] DP,
  output logic       FRAME_VALID,
  output logic       ERR,
  output logic       STALE
);

  localparam int STAB_W = $clog2(SETTLE_CYC + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(SETTLE_CYC);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(SETTLE_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);
  localparam logic [7:0] SEG_INV = {8{SEG_ACT_LOW}};
  localparam logic [3:0] DIG_INV = {4{DIG_ACT_LOW}};

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [7:0]        seg_raw_reg;
  logic [3:0]        dig_raw_reg;
  logic [7:0]        seg_n;
  logic [3:0]        dig_n;
  logic [7:0]        seg_prev_reg;
  logic [3:0]        dig_prev_reg;
  logic [STAB_W-1:0] stab_cnt_reg;
  logic [STAB_W-1:0] stab_cnt_next;
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              same_sample;
  logic              dig_one_hot;
  logic              stable;
  logic              capture;
  logic              dec_valid;
  logic [3:0]        dec_val;
  logic [3:0]        cap_ok;
  logic [3:0]        mask_reg;
  logic [3:0]        mask_next;
  logic              frame_full;
  logic              frame_valid_reg;
  logic              err_reg;
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic [IDLE_W-1:0] idle_cnt_next;
  logic              stale_next;
  logic              stale_reg;
  logic [3:0]        cnt_q [4];
  logic [3:0]        dp_q;

  // Raw pins are registered at their idle level so a reset mid-dwell forces a full re-settle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      seg_raw_reg  <= SEG_INV;
      dig_raw_reg  <= DIG_INV;
      seg_prev_reg <= 8'h00;
      dig_prev_reg <= 4'h0;
    end else begin
      seg_raw_reg  <= SEG;
      dig_raw_reg  <= DIG;
      seg_prev_reg <= seg_n;
      dig_prev_reg <= dig_n;
    end
  end

  assign seg_n = seg_raw_reg ^ SEG_INV;
  assign dig_n = dig_raw_reg ^ DIG_INV;

  assign dig_one_hot = (dig_n != 4'h0) && ((dig_n & (dig_n - 4'h1)) == 4'h0);
  assign same_sample = (seg_n == seg_prev_reg) && (dig_n == dig_prev_reg);
  assign stable      = same_sample && dig_one_hot;

  always_comb begin
    stab_cnt_next = '0;
    if (stable) begin
      if (stab_cnt_reg == STAB_MAX) begin
        stab_cnt_next = STAB_MAX;
      end else begin
        stab_cnt_next = stab_cnt_reg + STAB_W'(1);
      end
    end
  end

  // Capture fires on the edge where the stability count reaches SETTLE_CYC, once per dwell.
  assign capture = (state_reg != ST_HOLD) && stable && (stab_cnt_reg == STAB_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HUNT: begin
        if (capture) begin
          state_next = ST_HOLD;
        end else if (dig_one_hot) begin
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (capture) begin
          state_next = ST_HOLD;
        end else if (!stable) begin
          state_next = ST_HUNT;
        end
      end
      ST_HOLD: begin
        if (!same_sample) begin
          state_next = ST_HUNT;
        end
      end
      default: state_next = ST_HUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= ST_HUNT;
      stab_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      stab_cnt_reg <= stab_cnt_next;
    end
  end

  // Segment decode on {a..g}; the dp bit never influences validity.
  always_comb begin
    dec_valid = 1'b1;
    dec_val   = 4'hF;
    case (seg_n[7:1])
      7'h7E:   dec_val = 4'd0;
      7'h30:   dec_val = 4'd1;
      7'h6D:   dec_val = 4'd2;
      7'h79:   dec_val = 4'd3;
      7'h33:   dec_val = 4'd4;
      7'h5B:   dec_val = 4'd5;
      7'h5F:   dec_val = 4'd6;
      7'h70:   dec_val = 4'd7;
      7'h7F:   dec_val = 4'd8;
      7'h7B:   dec_val = 4'd9;
      7'h00:   dec_val = 4'hF;
      default: dec_valid = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] cnt_reg;

      assign cap_ok[gi] = capture & dec_valid & dig_n[gi];

      always_ff @(posedge CLK) begin
        if (RESET) begin
          cnt_reg <= 4'hF;
        end else if (cap_ok[gi]) begin
          cnt_reg <= dec_val;
        end
      end

      assign cnt_q[gi] = cnt_reg;

`ifdef SEVEN_SEG_RX_DP_CAPTURE_EN
      logic dp_reg;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          dp_reg <= 1'b0;
        end else if (cap_ok[gi]) begin
          dp_reg <= seg_n[0];
        end
      end

      assign dp_q[gi] = dp_reg;
`else
      assign dp_q[gi] = 1'b0;
`endif
    end
  endgenerate

  // A full mask never becomes visible: it turns into the frame pulse and clears on the same edge.
  assign mask_next  = mask_reg | cap_ok;
  assign frame_full = (|cap_ok) && (mask_next == 4'hF);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask_reg        <= 4'h0;
      frame_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      mask_reg        <= frame_full ? 4'h0 : mask_next;
      frame_valid_reg <= frame_full;
      err_reg         <= err_reg | (capture & ~dec_valid);
    end
  end

  always_comb begin
    idle_cnt_next = '0;
    if (!capture) begin
      if (idle_cnt_reg == IDLE_MAX) begin
        idle_cnt_next = IDLE_MAX;
      end else begin
        idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
      end
    end
  end

  assign stale_next = (idle_cnt_next == IDLE_MAX);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idle_cnt_reg <= '0;
      stale_reg    <= 1'b0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
      stale_reg    <= stale_next;
    end
  end

  assign CNT1        = cnt_q[0];
  assign CNT2        = cnt_q[1];
  assign CNT3        = cnt_q[2];
  assign CNT4        = cnt_q[3];
  assign DP          = dp_q;
  assign FRAME_VALID = frame_valid_reg;
  assign ERR         = err_reg;
  assign STALE       = stale_reg;

endmodule

// File: tb/tb_seven_seg_scan_receiver.sv
// Directed, table-driven bench for seven_seg_scan_receiver (SETTLE_CYC=4, TIMEOUT_CYC=100, active-low bus).
module tb_seven_seg_scan_receiver;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg;
  logic [3:0] dig;
  logic [3:0] cnt1, cnt2, cnt3, cnt4, dp;
  logic       frame_valid, err, stale;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] cnt_m [4];
  logic [3:0] dp_m;

  typedef struct {
    logic [6:0] seg7;
    logic       dp;
    int         idx;
    int         len;
    logic       upd;
    logic [3:0] val;
    logic       frame;
    logic       err;
  } vec_t;

  vec_t vecs [18];

  seven_seg_scan_receiver #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TIMEOUT),
    .SEG_ACT_LOW(1'b1),
    .DIG_ACT_LOW(1'b1)
  ) dut (
    .CLK        (clk),
    .RESET      (reset),
    .SEG        (seg),
    .DIG        (dig),
    .CNT1       (cnt1),
    .CNT2       (cnt2),
    .CNT3       (cnt3),
    .CNT4       (cnt4),
    .DP         (dp),
    .FRAME_VALID(frame_valid),
    .ERR        (err),
    .STALE      (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, " cnt1"}, 32'(cnt1), 32'(cnt_m[0]));
    check({tag, " cnt2"}, 32'(cnt2), 32'(cnt_m[1]));
    check({tag, " cnt3"}, 32'(cnt3), 32'(cnt_m[2]));
    check({tag, " cnt4"}, 32'(cnt4), 32'(cnt_m[3]));
  endtask

  task automatic drive_idle();
    seg = 8'hFF;
    dig = 4'hF;
  endtask

  // Drives one dwell right after a rising edge; capture is expected on the SETTLE+1-th edge.
  task automatic dwell(input logic [6:0] seg7, input logic dpb, input int idx, input int len,
                       input logic upd, input logic [3:0] val, input logic exp_frame,
                       input logic exp_err, input logic pre_stale);
    logic [3:0] oh;
    oh  = 4'b0001 << idx;
    seg = ~{seg7, dpb};
    dig = ~oh;
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      if (k == SETTLE) begin
        check_cnts("pre-capture");
        check("pre-capture stale", 32'(stale), 32'(pre_stale));
        check("pre-capture frame", 32'(frame_valid), 32'd0);
      end else if (k == SETTLE + 1) begin
        if (upd) begin
          cnt_m[idx] = val;
`ifdef SEVEN_SEG_RX_DP_CAPTURE_EN
          dp_m[idx] = dpb;
`endif
        end
        check_cnts("capture");
        check("capture dp", 32'(dp), 32'(dp_m));
        check("capture err", 32'(err), 32'(exp_err));
        check("capture frame", 32'(frame_valid), 32'(exp_frame));
        check("capture stale", 32'(stale), 32'd0);
        $display("dwell D%0d seg=%02h dp=%0b -> CNT=%h%h%h%h DP=%b ERR=%0b FV=%0b",
                 idx + 1, seg7, dpb, cnt1, cnt2, cnt3, cnt4, dp, err, frame_valid);
      end else if (k == SETTLE + 2) begin
        check("frame pulse width", 32'(frame_valid), 32'd0);
      end
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) cnt_m[i] = 4'hF;
    dp_m = 4'h0;
  endtask

  task automatic check_reset_state(input string tag);
    check_cnts(tag);
    check({tag, " dp"}, 32'(dp), 32'd0);
    check({tag, " frame"}, 32'(frame_valid), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " stale"}, 32'(stale), 32'd0);
  endtask

  initial begin
    //          seg7   dp    idx len upd  val   frame err
    vecs[0]  = '{7'h30, 1'b0, 0, 16, 1'b1, 4'h1, 1'b0, 1'b0};
    vecs[1]  = '{7'h6D, 1'b1, 1, 16, 1'b1, 4'h2, 1'b0, 1'b0};
    vecs[2]  = '{7'h79, 1'b0, 2, 16, 1'b1, 4'h3, 1'b0, 1'b0};
    vecs[3]  = '{7'h33, 1'b0, 3, 16, 1'b1, 4'h4, 1'b1, 1'b0};
    vecs[4]  = '{7'h5B, 1'b1, 0, 16, 1'b1, 4'h5, 1'b0, 1'b0};
    vecs[5]  = '{7'h5F, 1'b0, 1, 16, 1'b1, 4'h6, 1'b0, 1'b0};
    vecs[6]  = '{7'h70, 1'b0, 2, 16, 1'b1, 4'h7, 1'b0, 1'b0};
    vecs[7]  = '{7'h7F, 1'b0, 3, 16, 1'b1, 4'h8, 1'b1, 1'b0};
    vecs[8]  = '{7'h7B, 1'b0, 0, 16, 1'b1, 4'h9, 1'b0, 1'b0};
    vecs[9]  = '{7'h7E, 1'b0, 1, 16, 1'b1, 4'h0, 1'b0, 1'b0};
    vecs[10] = '{7'h00, 1'b0, 2, 16, 1'b1, 4'hF, 1'b0, 1'b0};
    vecs[11] = '{7'h30, 1'b0, 0, 16, 1'b1, 4'h1, 1'b0, 1'b0};
    vecs[12] = '{7'h33, 1'b0, 3, 16, 1'b1, 4'h4, 1'b1, 1'b0};
    vecs[13] = '{7'h01, 1'b1, 1, 10, 1'b0, 4'h0, 1'b0, 1'b1};
    vecs[14] = '{7'h6D, 1'b0, 1, 16, 1'b1, 4'h2, 1'b0, 1'b1};
    vecs[15] = '{7'h5B, 1'b0, 0, 16, 1'b1, 4'h5, 1'b0, 1'b1};
    vecs[16] = '{7'h79, 1'b0, 2, 16, 1'b1, 4'h3, 1'b0, 1'b1};
    vecs[17] = '{7'h70, 1'b0, 3, 16, 1'b1, 4'h7, 1'b1, 1'b1};

    reset = 1'b1;
    drive_idle();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");
    $display("reset: CNT=%h%h%h%h DP=%b ERR=%0b STALE=%0b", cnt1, cnt2, cnt3, cnt4, dp, err, stale);

    // Scan sequences, bad pattern, blanks and recaptures
    for (int v = 0; v < 18; v++) begin
      dwell(vecs[v].seg7, vecs[v].dp, vecs[v].idx, vecs[v].len, vecs[v].upd,
            vecs[v].val, vecs[v].frame, vecs[v].err, 1'b0);
    end

    // Short dwells (3 cycles each) must never capture
    seg = ~{7'h7E, 1'b0};
    dig = 4'b1110;
    repeat (3) @(posedge clk);
    #1;
    seg = ~{7'h5F, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check_cnts("glitch");
    drive_idle();
    repeat (8) @(posedge clk);
    #1;
    check_cnts("glitch settle");
    check("glitch frame", 32'(frame_valid), 32'd0);
    $display("glitch: CNT=%h%h%h%h", cnt1, cnt2, cnt3, cnt4);

    // Bus stops right after a capture: STALE exactly TIMEOUT edges later, then saturates
    dwell(7'h7E, 1'b0, 0, SETTLE + 2, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    drive_idle();
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge clk);
      #1;
      if (i == TIMEOUT - 1) check("stale early", 32'(stale), 32'd0);
      if (i == TIMEOUT) check("stale on time", 32'(stale), 32'd1);
    end
    repeat (20) @(posedge clk);
    #1;
    check("stale held", 32'(stale), 32'd1);
    $display("stale: STALE=%0b after %0d idle cycles", stale, TIMEOUT + 20);
    dwell(7'h7F, 1'b0, 1, 16, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a dwell discards it; settling restarts after reset
    seg = ~{7'h5F, 1'b0};
    dig = 4'b1011;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    check_reset_state("mid-dwell reset");
    dwell(7'h5F, 1'b0, 2, 16, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);

    drive_idle();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
